// File: rtl/bpm_lookup_arbiter_if.sv
// Two-deck period-to-BPM lookup bus: deck requests, shared table port and
// per-deck responses.
interface bpm_lookup_arbiter_if #(
  parameter int unsigned DATA_IN_BITS  = 11,
  parameter int unsigned DATA_OUT_BITS = 16
);
  logic [1:0]               req_valid;
  logic [DATA_IN_BITS-1:0]  req_period_a;
  logic [DATA_IN_BITS-1:0]  req_period_b;
  logic [1:0]               req_ready;
  logic [DATA_IN_BITS-1:0]  lut_period;
  logic [DATA_OUT_BITS-1:0] lut_bpm;
  logic [1:0]               rsp_valid;
  logic [DATA_OUT_BITS-1:0] rsp_bpm;
  logic                     rsp_error;
  logic                     busy;

  modport master (
    output req_valid, req_period_a, req_period_b, lut_bpm,
    input  req_ready, lut_period, rsp_valid, rsp_bpm, rsp_error, busy
  );

  modport slave (
    input  req_valid, req_period_a, req_period_b, lut_bpm,
    output req_ready, lut_period, rsp_valid, rsp_bpm, rsp_error, busy
  );
endinterface

// File: rtl/bpm_lookup_arbiter.sv
// Round-robin arbiter sharing one period-to-BPM table between two decks.
// BPM_CLAMP_EN: saturate out-of-range periods and look them up instead of failing fast.
module bpm_lookup_arbiter #(
  parameter int unsigned DATA_IN_BITS  = 11,
  parameter int unsigned DATA_OUT_BITS = 16,
  parameter int unsigned MIN_PERIOD    = 1181,
  parameter int unsigned MAX_PERIOD    = 1378,
  parameter int unsigned LUT_LATENCY   = 2
) (
  input logic clk,
  input logic rst,
  bpm_lookup_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = ($clog2(LUT_LATENCY + 1) > 0) ? $clog2(LUT_LATENCY + 1) : 1;
  localparam logic [DATA_IN_BITS-1:0] P_MIN = DATA_IN_BITS'(MIN_PERIOD);
  localparam logic [DATA_IN_BITS-1:0] P_MAX = DATA_IN_BITS'(MAX_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                   r_state;
  logic                     r_rr_b;
  logic                     r_id;
  logic                     r_err;
  logic [CNT_W-1:0]         r_cnt;
  logic [DATA_IN_BITS-1:0]  r_lut_period;
  logic [DATA_OUT_BITS-1:0] r_rsp_bpm;
  logic                     r_rsp_error;
  logic [1:0]               r_rsp_valid;

  logic                     w_accept;
  logic                     w_grant_b;
  logic [DATA_IN_BITS-1:0]  w_period;
  logic                     w_in_range;
  logic [DATA_IN_BITS-1:0]  w_sat_period;

  // r_rr_b set means deck B wins a tie; a lone requester always wins.
  always_comb begin
    w_accept     = (r_state == S_IDLE) && (|bus.req_valid) && !rst;
    w_grant_b    = bus.req_valid[1] && (!bus.req_valid[0] || r_rr_b);
    w_period     = w_grant_b ? bus.req_period_b : bus.req_period_a;
    w_in_range   = (w_period >= P_MIN) && (w_period <= P_MAX);
    w_sat_period = (w_period < P_MIN) ? P_MIN : ((w_period > P_MAX) ? P_MAX : w_period);
    bus.req_ready = '0;
    if (w_accept) begin
      bus.req_ready = w_grant_b ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_b       <= 1'b0;
      r_id         <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_lut_period <= P_MIN;
      r_rsp_bpm    <= '0;
      r_rsp_error  <= 1'b0;
      r_rsp_valid  <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id   <= w_grant_b;
            r_rr_b <= !w_grant_b;
            r_err  <= !w_in_range;
            r_cnt  <= '0;
`ifdef BPM_CLAMP_EN
            r_lut_period <= w_sat_period;
            r_state      <= S_WAIT;
`else
            if (w_in_range) begin
              r_lut_period <= w_period;
              r_state      <= S_WAIT;
            end else begin
              r_rsp_bpm   <= '0;
              r_rsp_error <= 1'b1;
              r_rsp_valid <= w_grant_b ? 2'b10 : 2'b01;
              r_state     <= S_RESP;
            end
`endif
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(LUT_LATENCY)) begin
            r_rsp_bpm   <= bus.lut_bpm;
            r_rsp_error <= r_err;
            r_rsp_valid <= r_id ? 2'b10 : 2'b01;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef BPM_CLAMP_EN
  logic w_sat_unused;
  assign w_sat_unused = ^w_sat_period;
`endif

  assign bus.lut_period = r_lut_period;
  assign bus.rsp_bpm    = r_rsp_bpm;
  assign bus.rsp_error  = r_rsp_error;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
